fifo_4096_pair: RTL and testbench
=================================

// Module: fifo_4096_pair
// PURPOSE
// - Input reorder buffer for a radix-2 FFT stage (8192-point, first stage).
// - Buffers the first half-frame (4096 samples), then emits each sample of the second half
//   alongside the sample exactly DEPTH positions earlier: x[n] and x[n+4096].
// - Feeds the first butterfly stage; one 40-bit complex sample per accepted input, {re[39:20], im[19:0]}.
// PARAMETERS
// - DATA_W  40    sample width (packed complex); data path opaque, no arithmetic on data
// - DEPTH   4096  half-frame length; frame = 2*DEPTH accepted samples
// - ADDR_W  12    log2(DEPTH); sample counter is ADDR_W+1 bits
// PORTS
// - clk             in   1       single clock, all logic on rising edge
// - rst             in   1       asynchronous, active-high reset
// - data_in         in   DATA_W  input sample
// - data_in_valid   in   1       qualifies data_in; one sample accepted per cycle when high
// - data_out1       out  DATA_W  earlier sample x[n] (first half-frame)
// - data_out2       out  DATA_W  later sample x[n+DEPTH] (second half-frame)
// - data_out_valid  out  1       data_out1/data_out2 pair valid this cycle
// BEHAVIOUR
// - Interface: one clock (clk); reset asynchronous, active-high (rst).
// - Reset: cnt=0, data_out1=0, data_out2=0, data_out_valid=0; RAM contents not cleared.
// - cnt (ADDR_W+1 bits) counts accepted samples; increments only when data_in_valid=1.
//   Wraps 2*DEPTH-1 -> 0; no other state machine.
// - Phase WRITE (cnt[ADDR_W]=0): RAM[cnt[ADDR_W-1:0]] <= data_in; data_out_valid=0 next cycle.
// - Phase PAIR (cnt[ADDR_W]=1): synchronous read of RAM[cnt[ADDR_W-1:0]] (same address as its
//   first-half partner); data_in registered once for alignment.
//   - Next cycle: data_out1 = RAM word, data_out2 = registered data_in, data_out_valid=1.
// - Latency: pair valid exactly 1 clk after the second-half sample is accepted.
// - data_in_valid=0: no write, cnt holds; data_out_valid=0 next cycle;
//   data_out1/data_out2 hold last values.
// - Gaps allowed anywhere; pairing is by accepted-sample index, not by cycle.
// - Frame wrap: sample at cnt=2*DEPTH-1 yields the last pair; the next accepted sample is
//   written at address 0 (new frame). No overflow/underflow conditions exist.
// - Reset mid-frame: partial frame discarded; next accepted sample is frame sample 0.
// - No backpressure: output consumer must accept every valid pair.
// - RAM: DEPTH x DATA_W, single write port + single synchronous read port (infer block RAM).
// CONFIGURATION
// - FIFO_PAIR_OUT_REG_EN defined:
//   - extra register stage on data_out1, data_out2 and data_out_valid;
//   - latency becomes 2 clk; reset values unchanged (0).
// - Not defined: latency 1 clk as above.
// TESTING
// - Reset: assert rst 100 ns with clk idle -> all outputs 0; deassert -> outputs stay 0
//   until the first pair.
// - Continuous ramp: data_in_valid=1, data_in=1,2,3,... -> no valid for inputs 1..4096.
//   - One clk after input 4097: data_out1=1, data_out2=4097, valid=1.
//   - Last pair: (4096, 8192), then valid=0.
// - Frame wrap: continue ramp past 8192 (restart at 1) -> 4096 cycles of valid=0.
//   - Next pair: (1, 4097); no stale data from the previous frame.
// - Gaps: drop data_in_valid for 3 cycles during both halves -> pairs still (k, k+4096),
//   valid low only in the cycles following gaps, outputs held.
// - Mid-frame reset: assert rst after 6000 samples -> valid=0 immediately; restart ramp at 1.
//   - First pair after 4097 accepted samples: (1, 4097).
// - FIFO_PAIR_OUT_REG_EN defined: rerun continuous ramp -> identical pairs, each 1 clk later.

Source files
------------

// File: rtl/fifo_4096_pair_if.sv
// Sample-in / pair-out bundle for the FFT input reorder buffer.
interface fifo_4096_pair_if #(
  parameter int DATA_W = 40
);
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic [DATA_W-1:0] data_out1;
  logic [DATA_W-1:0] data_out2;
  logic              data_out_valid;

  modport master (
    output data_in, data_in_valid,
    input  data_out1, data_out2, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid,
    output data_out1, data_out2, data_out_valid
  );
endinterface

// File: rtl/fifo_4096_pair.sv
// Radix-2 FFT input reorder: pairs x[n] with x[n+DEPTH] over a 2*DEPTH frame.
// Optional macro FIFO_PAIR_OUT_REG_EN adds one output register stage (latency 2).
module fifo_4096_pair #(
  parameter int DATA_W = 40,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input logic             clk,
  input logic             rst,
  fifo_4096_pair_if.slave bus
);

  logic [ADDR_W:0]   cnt;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_en;

  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] ram_q_p1;
  logic [DATA_W-1:0] din_p1;
  logic              seen_p1;
  logic              vld_p1;
  logic [DATA_W-1:0] out1_p1;

  assign addr  = cnt[ADDR_W-1:0];
  assign wr_en = bus.data_in_valid && !cnt[ADDR_W];
  assign rd_en = bus.data_in_valid &&  cnt[ADDR_W];

  // Frame counter wraps naturally at 2*DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (bus.data_in_valid) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage p0 -> p1: RAM is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[addr] <= bus.data_in;
    end
    if (rd_en) begin
      ram_q_p1 <= ram[addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      din_p1  <= '0;
      seen_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_en;
      if (rd_en) begin
        din_p1  <= bus.data_in;
        seen_p1 <= 1'b1;
      end
    end
  end

  // The unreset RAM read register is masked until the first pair after reset.
  assign out1_p1 = seen_p1 ? ram_q_p1 : '0;

`ifdef FIFO_PAIR_OUT_REG_EN
  logic [DATA_W-1:0] out1_p2;
  logic [DATA_W-1:0] out2_p2;
  logic              vld_p2;

  // Stage p1 -> p2
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out1_p2 <= '0;
      out2_p2 <= '0;
      vld_p2  <= 1'b0;
    end else begin
      out1_p2 <= out1_p1;
      out2_p2 <= din_p1;
      vld_p2  <= vld_p1;
    end
  end

  assign bus.data_out1      = out1_p2;
  assign bus.data_out2      = out2_p2;
  assign bus.data_out_valid = vld_p2;
`else
  assign bus.data_out1      = out1_p1;
  assign bus.data_out2      = din_p1;
  assign bus.data_out_valid = vld_p1;
`endif

endmodule

// File: tb/tb_fifo_4096_pair.sv
// Scoreboard bench for fifo_4096_pair: driver queues expected pairs, monitor checks them.
module tb_fifo_4096_pair;

`ifdef FIFO_PAIR_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int HALF = 4096;

  typedef struct {
    logic [39:0] d1;
    logic [39:0] d2;
    logic [39:0] cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b0;
  logic        run = 1'b0;
  logic [39:0] cyc = '0;
  logic [39:0] last1 = '0;
  logic [39:0] last2 = '0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];

  fifo_4096_pair_if #(.DATA_W(40)) ifc ();

  fifo_4096_pair dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1'b1;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // Monitor: pops on every valid pair, otherwise checks outputs are held.
  always @(negedge clk) begin
    exp_t e;
    if (run && !rst) begin
      if (ifc.data_out_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_valid got=1 want=0 at cyc=%0d", cyc);
        end else begin
          e = q.pop_front();
          chk("pair_d1", ifc.data_out1, e.d1);
          chk("pair_d2", ifc.data_out2, e.d2);
          chk("pair_cycle", cyc, e.cyc);
          last1 = e.d1;
          last2 = e.d2;
        end
      end else begin
        chk("hold_d1", ifc.data_out1, last1);
        chk("hold_d2", ifc.data_out2, last2);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          total++;
          bad++;
          $display("FAIL missing_pair got=none want=%0h/%0h at cyc=%0d", q[0].d1, q[0].d2, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  // Sample i (1-based) of a frame carries base+i; second-half samples complete a pair.
  task automatic send(input logic [39:0] base, input int i);
    exp_t e;
    @(posedge clk);
    #1;
    ifc.data_in_valid = 1'b1;
    ifc.data_in       = base + 40'(i);
    if (i > HALF) begin
      e.d1  = base + 40'(i - HALF);
      e.d2  = base + 40'(i);
      e.cyc = cyc + 40'(LAT);
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ifc.data_in_valid = 1'b0;
      ifc.data_in       = 40'hdead_beef_0;
    end
  endtask

  task automatic frame(input logic [39:0] base, input int n, input int g1, input int g2);
    for (int i = 1; i <= n; i++) begin
      if (i == g1 || i == g2) idle(3);
      send(base, i);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.data_in_valid = 1'b0;
    ifc.data_in       = '0;
    rst = 1'b1;
    #100;
    chk("reset_valid", 40'(ifc.data_out_valid), 40'd0);
    chk("reset_d1", ifc.data_out1, 40'd0);
    chk("reset_d2", ifc.data_out2, 40'd0);
    rst = 1'b0;
    #2;
    clk_en = 1'b1;
    run    = 1'b1;

    // Continuous ramp 1..8192, then a second frame with a distinct tag.
    frame(40'h0, 2 * HALF, 0, 0);
    frame(40'h00100000, 2 * HALF, 0, 0);

    // Gaps in both halves.
    frame(40'h00200000, 2 * HALF, 100, 5000);
    idle(LAT + 2);
    chk("queue_drained_before_reset", 40'(q.size()), 40'd0);

    // Mid-frame reset after 6000 samples, then a clean frame.
    frame(40'h00300000, 6000, 0, 0);
    idle(1);
    @(negedge clk);
    #1;
    last1 = '0;
    last2 = '0;
    rst   = 1'b1;
    #1;
    chk("midreset_valid", 40'(ifc.data_out_valid), 40'd0);
    chk("midreset_d1", ifc.data_out1, 40'd0);
    chk("midreset_d2", ifc.data_out2, 40'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    frame(40'h00400000, 2 * HALF, 0, 0);
    idle(LAT + 3);
    chk("queue_drained_at_end", 40'(q.size()), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
